aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander.sv | 169 ++++++++++++++++
 tb/tb_aes_key_expander.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// AES key schedule generator for 128/192/256-bit keys: expands one word per cycle
// into local storage and serves round keys through a registered read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // Row r holds entries 16r..16r+15, entry 0 in the most significant byte.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = TABLE[{~a, 3'b111} -: 8];
endmodule

// state  | meaning
// IDLE   | no schedule yet, waiting for a key
// EXPAND | generating one schedule word per cycle
// DONE   | schedule complete and readable, new key may be accepted
module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  input  logic [3:0]          rd_idx,
  output logic                rd_valid,
  output logic [127:0]        rd_key,
  output logic                rd_err
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [2:0] KMAX = 3'(NK - 1);
  localparam logic [3:0] RMAX = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [5:0]   widx;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [7:0]   rcon_nxt;
  logic         accept;
  logic [31:0]  w [NW];
  logic [31:0]  wprev;
  logic [31:0]  wback;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [5:0]   rd_base;
  logic [127:0] rd_data;
  logic         rd_ok;

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);
  assign accept    = key_valid & key_ready;
  assign rcon_nxt  = rcon[7] ? 8'h1b : {rcon[6:0], 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (key_valid) state_nxt = EXPAND;
      EXPAND:     if (widx == LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Word generation: w[i] = w[i-Nk] ^ temp, temp chosen by i mod Nk.
  assign wprev  = w[widx - 6'd1];
  assign wback  = w[widx - 6'(NK)];
  assign sub_in = (kmod == 3'd0) ? {wprev[7:0], wprev[31:8]} : wprev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = wprev;
    if (kmod == 3'd0)
      temp = sub_out ^ {24'h0, rcon};
    else if (NK == 8 && kmod == 3'd4)
      temp = sub_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      widx  <= '0;
      kmod  <= '0;
      rcon  <= 8'h01;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        widx <= 6'(NK);
        kmod <= '0;
        rcon <= 8'h01;
        done <= 1'b0;
      end else if (state == EXPAND) begin
        widx <= widx + 6'd1;
        kmod <= (kmod == KMAX) ? 3'd0 : kmod + 3'd1;
        if (kmod == 3'd0) rcon <= rcon_nxt;
        if (widx == LAST) done <= 1'b1;
      end
    end
  end

  // Storage is not reset; done=0 keeps stale words from being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[32*j +: 32];
    end else if (state == EXPAND) begin
      w[widx] <= wback ^ temp;
    end
  end

  // A read coinciding with a key accept sees the schedule as already invalid.
  assign rd_ok   = done & ~accept & (rd_idx <= RMAX);
  assign rd_base = {rd_idx, 2'b00};

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < 4; j++) rd_data[32*j +: 32] = w[rd_base + 6'(j)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err <= ~rd_ok;
        rd_key <= rd_ok ? rd_data : 128'h0;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed and random checks of aes_key_expander in all three key sizes against
// an independently derived S-box and key-schedule model.

module tb_aes_key_expander;
  logic         clk;
  logic         rst_n;
  logic [255:0] key_in_a [3];
  logic         kv       [3];
  logic         kr       [3];
  logic         busy_a   [3];
  logic         done_a   [3];
  logic         rd_en_a  [3];
  logic [3:0]   rd_idx_a [3];
  logic         rv       [3];
  logic [127:0] rk       [3];
  logic         re       [3];

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  aes_key_expander #(.KEY_BITS(128)) u_k128 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_a[0][127:0]), .key_valid(kv[0]),
    .key_ready(kr[0]), .busy(busy_a[0]), .done(done_a[0]), .rd_en(rd_en_a[0]),
    .rd_idx(rd_idx_a[0]), .rd_valid(rv[0]), .rd_key(rk[0]), .rd_err(re[0]));

  aes_key_expander #(.KEY_BITS(192)) u_k192 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_a[1][191:0]), .key_valid(kv[1]),
    .key_ready(kr[1]), .busy(busy_a[1]), .done(done_a[1]), .rd_en(rd_en_a[1]),
    .rd_idx(rd_idx_a[1]), .rd_valid(rv[1]), .rd_key(rk[1]), .rd_err(re[1]));

  aes_key_expander #(.KEY_BITS(256)) u_k256 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_a[2]), .key_valid(kv[2]),
    .key_ready(kr[2]), .busy(busy_a[2]), .done(done_a[2]), .rd_en(rd_en_a[2]),
    .rd_idx(rd_idx_a[2]), .rd_valid(rv[2]), .rd_key(rk[2]), .rd_err(re[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [15:0] d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < nk; j++) mw[j] = key[32*j +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic int nk_of(int c);
    return 4 + 2 * c;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_done(input int c);
    int n = 0;
    int nk = nk_of(c);
    do begin
      tick();
      n++;
    end while (!done_a[c] && n < 100);
    chk($sformatf("c%0d latency", c), 128'(n), 128'(4 * (nk + 7) - nk));
  endtask

  task automatic load_key(input int c, input logic [255:0] k);
    model_expand(k, nk_of(c));
    kv[c] = 1'b1;
    key_in_a[c] = k;
    tick();
    kv[c] = 1'b0;
    chk($sformatf("c%0d busy after accept", c), 128'(busy_a[c]), 128'd1);
    chk($sformatf("c%0d ready in expand", c), 128'(kr[c]), 128'd0);
    wait_done(c);
  endtask

  task automatic read_one(input int c, input int idx);
    rd_en_a[c] = 1'b1;
    rd_idx_a[c] = 4'(idx);
    tick();
    rd_en_a[c] = 1'b0;
  endtask

  task automatic read_all(input int c);
    int nr = nk_of(c) + 6;
    logic [127:0] exp_key;
    for (int k = 0; k <= nr + 1; k++) begin
      rd_en_a[c] = 1'b1;
      rd_idx_a[c] = 4'(k);
      tick();
      exp_key = '0;
      if (k <= nr) exp_key = {mw[4*k+3], mw[4*k+2], mw[4*k+1], mw[4*k]};
      chk($sformatf("c%0d idx%0d valid", c, k), 128'(rv[c]), 128'd1);
      chk($sformatf("c%0d idx%0d err", c, k), 128'(re[c]), 128'(k > nr));
      chk($sformatf("c%0d idx%0d key", c, k), rk[c], exp_key);
    end
    rd_idx_a[c] = 4'd1;
    tick();
    rd_en_a[c] = 1'b0;
    tick();
    chk($sformatf("c%0d idle valid", c), 128'(rv[c]), 128'd0);
    chk($sformatf("c%0d hold key", c), rk[c], {mw[7], mw[6], mw[5], mw[4]});
    chk($sformatf("c%0d hold err", c), 128'(re[c]), 128'd0);
  endtask

  localparam logic [255:0] K128 = 256'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [255:0] K192 = 256'h17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [255:0] K256 = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;

  initial begin
    logic [255:0] kb;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      key_in_a[c] = '0;
      kv[c] = 1'b0;
      rd_en_a[c] = 1'b0;
      rd_idx_a[c] = '0;
    end
    build_sbox();
    #2;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("c%0d rst ready", c), 128'(kr[c]), 128'd1);
      chk($sformatf("c%0d rst busy", c), 128'(busy_a[c]), 128'd0);
      chk($sformatf("c%0d rst done", c), 128'(done_a[c]), 128'd0);
      chk($sformatf("c%0d rst rd_valid", c), 128'(rv[c]), 128'd0);
      chk($sformatf("c%0d rst rd_err", c), 128'(re[c]), 128'd0);
      chk($sformatf("c%0d rst rd_key", c), rk[c], 128'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Golden FIPS-197 schedules
    load_key(0, K128);
    read_all(0);
    read_one(0, 10);
    chk("k128 idx10 golden", rk[0], 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0);
    read_one(0, 0);
    chk("k128 idx0 golden", rk[0], K128[127:0]);
    chk("k128 rcon final", 128'(u_k128.rcon), 128'h6c);

    load_key(1, K192);
    read_all(1);
    read_one(1, 13);
    chk("k192 idx13 err", 128'(re[1]), 128'd1);
    chk("k192 idx13 key", rk[1], 128'd0);
    chk("k192 rcon final", 128'(u_k192.rcon), 128'h1b);

    load_key(2, K256);
    read_all(2);
    read_one(2, 14);
    chk("k256 idx14 golden", rk[2], 128'h36de686d_3cc21a37_e97909bf_cc79fc24);
    chk("k256 rcon final", 128'(u_k256.rcon), 128'h80);

    // key_valid held through EXPAND with a changing key
    model_expand(K128, 4);
    kv[0] = 1'b1;
    key_in_a[0] = K128;
    tick();
    begin
      int n = 0;
      do begin
        key_in_a[0] = rand_key();
        tick();
        n++;
        if (!done_a[0]) chk("hold ready low", 128'(kr[0]), 128'd0);
      end while (!done_a[0] && n < 100);
      kv[0] = 1'b0;
      chk("hold latency", 128'(n), 128'd40);
    end
    read_all(0);

    // New key in DONE with a read on the accept edge
    kb = rand_key();
    model_expand(kb, 4);
    kv[0] = 1'b1;
    key_in_a[0] = kb;
    rd_en_a[0] = 1'b1;
    rd_idx_a[0] = 4'd0;
    tick();
    kv[0] = 1'b0;
    rd_en_a[0] = 1'b0;
    chk("rekey done drop", 128'(done_a[0]), 128'd0);
    chk("rekey busy", 128'(busy_a[0]), 128'd1);
    chk("rekey rd_valid", 128'(rv[0]), 128'd1);
    chk("rekey rd_err", 128'(re[0]), 128'd1);
    chk("rekey rd_key", rk[0], 128'd0);
    wait_done(0);
    read_all(0);

    // Asynchronous reset in the middle of an expansion
    model_expand(K128, 4);
    kv[0] = 1'b1;
    key_in_a[0] = K128;
    tick();
    kv[0] = 1'b0;
    repeat (20) tick();
    chk("pre-reset busy", 128'(busy_a[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 128'(busy_a[0]), 128'd0);
    chk("async rst ready", 128'(kr[0]), 128'd1);
    for (int c = 0; c < 3; c++)
      chk($sformatf("c%0d async rst done", c), 128'(done_a[c]), 128'd0);
    #1 rst_n = 1'b1;
    read_one(0, 0);
    chk("read before done err", 128'(re[0]), 128'd1);
    chk("read before done key", rk[0], 128'd0);
    load_key(0, K128);
    read_all(0);

    // Random keys in every configuration
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 2; r++) begin
        load_key(c, rand_key());
        read_all(c);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
